iteration_sequencer: RTL and testbench

ITERATION_SEQUENCER -- requirements
Module: iteration_sequencer

---
 rtl/iteration_sequencer_if.sv | 22 ++
 rtl/iteration_sequencer.sv | 144 ++++++++++++++
 tb/tb_iteration_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iteration_sequencer_if.sv
// Request/response handshake between the iteration sequencer and its update engine.
// The master drives requests carrying the current estimate; the slave answers with a new value.
interface iteration_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] est_val;
  logic             upd_valid;
  logic             upd_ready;
  logic [WIDTH-1:0] upd_val;

  modport master (
    output req_valid, est_val, upd_ready,
    input  req_ready, upd_valid, upd_val
  );

  modport slave (
    input  req_valid, est_val, upd_ready,
    output req_ready, upd_valid, upd_val
  );
endinterface

// File: rtl/iteration_sequencer.sv
// Iterative-solve sequencer: sends the estimate out, takes back a new one and stops on convergence or limit.
// Optional stall watchdog in WAIT is enabled by defining ITERSEQ_STALL_WDOG_EN.
module iteration_sequencer #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    seed,
  input  logic [WIDTH-1:0]    err_tol,
  input  logic [WIDTH-1:0]    min_tol,
  input  logic [ITER_W-1:0]   max_iter,
  iteration_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                conv_flag,
  output logic                timeout,
  output logic [ITER_W-1:0]   iter_cnt
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FINISH} state_t;

  state_t                   state;
  logic                     req_valid;
  logic                     upd_ready;
  logic [WIDTH-1:0]         est_val;
  logic [WIDTH-1:0]         new_val;
  logic signed [WIDTH-1:0]  err_tol_lat;
  logic signed [WIDTH-1:0]  min_tol_lat;
  logic [ITER_W-1:0]        max_iter_lat;
  logic [ITER_W-1:0]        iter_next;
`ifdef ITERSEQ_STALL_WDOG_EN
  logic [3:0]               wdog;
`endif

  // The low WIDTH bits of the (WIDTH+1)-bit zero-extended difference equal a plain WIDTH-bit subtraction.
  function automatic logic converged(input logic [WIDTH-1:0] old_v,
                                     input logic [WIDTH-1:0] new_v,
                                     input logic signed [WIDTH-1:0] hi,
                                     input logic signed [WIDTH-1:0] lo);
    logic signed [WIDTH-1:0] delta;
    delta = signed'(old_v - new_v);
    return (delta < hi) && (delta > lo);
  endfunction

  assign iter_next     = iter_cnt + ITER_W'(1);
  assign bus.req_valid = req_valid;
  assign bus.upd_ready = upd_ready;
  assign bus.est_val   = est_val;

  // Operand registers: only meaningful while a solve is active, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      err_tol_lat  <= signed'(err_tol);
      min_tol_lat  <= signed'(min_tol);
      max_iter_lat <= max_iter;
    end
    if (state == WAIT && bus.upd_valid) begin
      new_val <= bus.upd_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      est_val   <= '0;
      iter_cnt  <= '0;
      req_valid <= 1'b0;
      upd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      conv_flag <= 1'b0;
      timeout   <= 1'b0;
`ifdef ITERSEQ_STALL_WDOG_EN
      wdog      <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            est_val   <= seed;
            iter_cnt  <= '0;
            conv_flag <= 1'b0;
            timeout   <= 1'b0;
            req_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.req_ready) begin
            req_valid <= 1'b0;
            upd_ready <= 1'b1;
            state     <= WAIT;
`ifdef ITERSEQ_STALL_WDOG_EN
            wdog      <= 4'd0;
`endif
          end
        end
        WAIT: begin
          if (bus.upd_valid) begin
            upd_ready <= 1'b0;
            state     <= CHECK;
          end
`ifdef ITERSEQ_STALL_WDOG_EN
          // Fifteenth consecutive stalled cycle abandons the solve without counting an iteration.
          else if (wdog == 4'd14) begin
            upd_ready <= 1'b0;
            timeout   <= 1'b1;
            done      <= 1'b1;
            state     <= FINISH;
          end else begin
            wdog <= wdog + 4'd1;
          end
`endif
        end
        CHECK: begin
          iter_cnt <= iter_next;
          est_val  <= new_val;
          if (converged(est_val, new_val, err_tol_lat, min_tol_lat)) begin
            conv_flag <= 1'b1;
            done      <= 1'b1;
            state     <= FINISH;
          end else if (iter_next == max_iter_lat) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= FINISH;
          end else begin
            req_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iteration_sequencer.sv
// Scoreboard bench for iteration_sequencer: directed solves with hand-computed requests and results.
// Build with ITERSEQ_STALL_WDOG_EN defined to exercise the stall watchdog instead of the indefinite wait.
module tb_iteration_sequencer;
  localparam int WIDTH  = 8;
  localparam int ITER_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  seed = '0;
  logic [WIDTH-1:0]  err_tol = '0;
  logic [WIDTH-1:0]  min_tol = '0;
  logic [ITER_W-1:0] max_iter = '0;
  logic              busy, done, conv_flag, timeout;
  logic [ITER_W-1:0] iter_cnt;

  iteration_sequencer_if #(.WIDTH(WIDTH)) bus ();

  iteration_sequencer #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .err_tol(err_tol),
    .min_tol(min_tol), .max_iter(max_iter), .bus(bus), .busy(busy), .done(done),
    .conv_flag(conv_flag), .timeout(timeout), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       conv;
    logic       to;
    logic [7:0] iter;
    logic [7:0] est;
  } res_t;

  logic [7:0] exp_req[$];
  res_t       exp_res[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic expect_result(input logic c, input logic t, input logic [7:0] it, input logic [7:0] e);
    res_t r;
    r.conv = c; r.to = t; r.iter = it; r.est = e;
    exp_res.push_back(r);
  endtask

  // Monitor: every accepted request and every DONE pulse is checked against the queues.
  always @(negedge clk) begin
    if (bus.req_valid && bus.req_ready) begin
      if (exp_req.size() == 0) begin
        total_cnt++;
        $display("FAIL req_unexpected: got est_val %0h, required no request", bus.est_val);
      end else check("req_est_val", bus.est_val, exp_req.pop_front());
    end
    if (done) begin
      if (exp_res.size() == 0) begin
        total_cnt++;
        $display("FAIL done_unexpected: got done=1, required no result");
      end else begin
        res_t r;
        r = exp_res.pop_front();
        check("res_conv_flag", conv_flag, r.conv);
        check("res_timeout", timeout, r.to);
        check("res_iter_cnt", iter_cnt, r.iter);
        check("res_est_val", bus.est_val, r.est);
        check("res_busy", busy, 1'b1);
      end
    end
  end

  task automatic start_solve(input logic [7:0] s, input logic [7:0] et, input logic [7:0] mt,
                             input logic [7:0] mi);
    seed = s; err_tol = et; min_tol = mt; max_iter = mi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic serve(input logic [7:0] v);
    int n;
    n = 0;
    while (!bus.req_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.req_valid) begin
      total_cnt++;
      $display("FAIL req_wait: got req_valid 0 after 50 cycles, required 1");
      return;
    end
    bus.req_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_ready = 1'b0;
    bus.upd_valid = 1'b1;
    bus.upd_val   = v;
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    if (!done) begin
      total_cnt++;
      $display("FAIL done_wait: got done 0 after 100 cycles, required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_est_val"}, bus.est_val, 8'h00);
    check({tag, "_iter_cnt"}, iter_cnt, 8'h00);
    check({tag, "_req_valid"}, bus.req_valid, 1'b0);
    check({tag, "_upd_ready"}, bus.upd_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_conv_flag"}, conv_flag, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
  endtask

  initial begin
    bus.req_ready = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_val   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(posedge clk); #1;

    // Converge: deltas -10 then -2
    exp_req.push_back(8'd10); exp_req.push_back(8'd20);
    expect_result(1'b1, 1'b0, 8'd2, 8'd22);
    start_solve(8'd10, 8'd4, 8'hFC, 8'd8);
    serve(8'd20); serve(8'd22);
    wait_done();

    // Results held in IDLE
    repeat (3) @(posedge clk);
    #1;
    check("hold_conv_flag", conv_flag, 1'b1);
    check("hold_iter_cnt", iter_cnt, 8'd2);
    check("hold_est_val", bus.est_val, 8'd22);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);

    // Iteration limit: deltas 100, -50, 50
    exp_req.push_back(8'd100); exp_req.push_back(8'd0); exp_req.push_back(8'd50);
    expect_result(1'b0, 1'b1, 8'd3, 8'd0);
    start_solve(8'd100, 8'd4, 8'hFC, 8'd3);
    serve(8'd0); serve(8'd50); serve(8'd0);
    wait_done();

    // Wrap: 0x7F-0x80 = -1 converges; 0x00-0x80 = -128 does not
    exp_req.push_back(8'h7F);
    expect_result(1'b1, 1'b0, 8'd1, 8'h80);
    start_solve(8'h7F, 8'd4, 8'hFC, 8'd8);
    serve(8'h80);
    wait_done();
    exp_req.push_back(8'h00);
    expect_result(1'b0, 1'b1, 8'd1, 8'h80);
    start_solve(8'h00, 8'd4, 8'hFC, 8'd1);
    serve(8'h80);
    wait_done();

    // Strict bounds: delta +4 and -4 fail, delta +3 converges and beats the limit
    exp_req.push_back(8'd10);
    expect_result(1'b0, 1'b1, 8'd1, 8'd6);
    start_solve(8'd10, 8'd4, 8'hFC, 8'd1);
    serve(8'd6);
    wait_done();
    exp_req.push_back(8'd6);
    expect_result(1'b0, 1'b1, 8'd1, 8'd10);
    start_solve(8'd6, 8'd4, 8'hFC, 8'd1);
    serve(8'd10);
    wait_done();
    exp_req.push_back(8'd9);
    expect_result(1'b1, 1'b0, 8'd1, 8'd6);
    start_solve(8'd9, 8'd4, 8'hFC, 8'd1);
    serve(8'd6);
    wait_done();

    // Request stall, START while busy, and tolerance inputs changed after start
    exp_req.push_back(8'd33);
    expect_result(1'b1, 1'b0, 8'd1, 8'd33);
    start_solve(8'd33, 8'd4, 8'hFC, 8'd1);
    err_tol = 8'd0; max_iter = 8'd0;
    for (int i = 0; i < 5; i++) begin
      check("stall_req_valid", bus.req_valid, 1'b1);
      check("stall_est_val", bus.est_val, 8'd33);
      start = (i == 1);
      seed  = 8'd99;
      @(posedge clk); #1;
    end
    start = 1'b0;
    serve(8'd33);
    wait_done();

    // Reset in the middle of WAIT, then a late response that must be ignored
    exp_req.push_back(8'd50);
    start_solve(8'd50, 8'd4, 8'hFC, 8'd8);
    bus.req_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_ready = 1'b0;
    check("wait_upd_ready", bus.upd_ready, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.upd_valid = 1'b1; bus.upd_val = 8'd50;
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    @(posedge clk); #1;
    check("late_resp_busy", busy, 1'b0);
    check("late_resp_iter", iter_cnt, 8'd0);
    exp_req.push_back(8'd5);
    expect_result(1'b1, 1'b0, 8'd1, 8'd5);
    start_solve(8'd5, 8'd4, 8'hFC, 8'd8);
    serve(8'd5);
    wait_done();

    // Response withheld in WAIT
    begin
      int n;
      int ready_cycles;
      exp_req.push_back(8'd7);
`ifdef ITERSEQ_STALL_WDOG_EN
      expect_result(1'b0, 1'b1, 8'd0, 8'd7);
`else
      expect_result(1'b1, 1'b0, 8'd1, 8'd7);
`endif
      start_solve(8'd7, 8'd4, 8'hFC, 8'd8);
      bus.req_ready = 1'b1;
      @(posedge clk); #1;
      bus.req_ready = 1'b0;
      n = 0; ready_cycles = 0;
`ifdef ITERSEQ_STALL_WDOG_EN
      while (!done && n < 40) begin
        if (bus.upd_ready) ready_cycles++;
        @(posedge clk); #1; n++;
      end
      check("wdog_done", done, 1'b1);
      check("wdog_wait_cycles", ready_cycles, 15);
      @(posedge clk); #1;
`else
      while (n < 30) begin
        if (bus.upd_ready && busy) ready_cycles++;
        @(posedge clk); #1; n++;
      end
      check("hold_wait_cycles", ready_cycles, 30);
      bus.upd_valid = 1'b1; bus.upd_val = 8'd7;
      @(posedge clk); #1;
      bus.upd_valid = 1'b0;
      wait_done();
`endif
    end

    @(negedge clk);
    check("req_queue_empty", exp_req.size(), 0);
    check("res_queue_empty", exp_res.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
